stream_fifo: RTL and testbench

- Synchronous valid/ready FIFO that sits directly upstream of the test_v datapath stage inside Test.
- Decouples the producer from test_v back-pressure and absorbs short bursts.
- First-word-fall-through: head entry is presented on out_data whenever out_valid=1.
- Single clock domain. Provides occupancy and status flags for top-level debug.

---
 rtl/stream_fifo.sv | 48 ++++
 tb/tb_stream_fifo.sv | 137 +++++++++++++
 2 files changed

// File: rtl/stream_fifo.sv
// stream_fifo: first-word-fall-through valid/ready FIFO with occupancy, status flags and sticky overflow
module stream_fifo #(
  parameter int DW = 32,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty,
  output logic          ovf_sticky
);
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    empty = count == '0;
    in_ready = !full;
    out_valid = !empty;
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
    out_data = empty ? '0 : mem[rd_ptr];
  end
  always_ff @(posedge clk)
    if (!rst && !flush && push) mem[wr_ptr] <= in_data;
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= push && !pop ? count + (AW+1)'(1) : pop && !push ? count - (AW+1)'(1) : count;
      if (in_valid && full) ovf_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_fifo.sv
// tb_stream_fifo: directed self-checking bench for stream_fifo at DW=8, DEPTH=4
module tb_stream_fifo;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [7:0] in_data = 0, out_data;
  logic in_ready, out_valid, full, empty, ovf_sticky;
  logic [2:0] count;
  int checks = 0, errors = 0;
  stream_fifo #(.DW(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .ovf_sticky(ovf_sticky)
  );
  always #5 clk = ~clk;
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [7:0] d);
    in_valid = 1;
    in_data = d;
    step;
    in_valid = 0;
  endtask
  task automatic clear_scenario(input bit use_rst);
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    push(8'hEE);
    chk("pre_ovf", ovf_sticky, 1);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("pre_cnt3", count, 3);
    if (use_rst) rst = 1; else flush = 1;
    in_valid = 1;
    in_data = 8'h77;
    out_ready = 1;
    step;
    rst = 0;
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    chk("clr_count", count, 0);
    chk("clr_empty", empty, 1);
    chk("clr_ovf", ovf_sticky, 0);
    chk("clr_data", out_data, 0);
    chk("clr_ready", in_ready, 1);
    push(8'h5A);
    chk("post_data", out_data, 8'h5A);
    chk("post_count", count, 1);
    out_ready = 1;
    step;
    out_ready = 0;
    chk("post_empty", empty, 1);
  endtask
  initial begin
    step;
    step;
    rst = 0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_ovf", ovf_sticky, 0);
    step;
    chk("idle_count", count, 0);
    push(8'h11);
    chk("fwft_valid", out_valid, 1);
    chk("fwft_data", out_data, 8'h11);
    chk("fwft_count", count, 1);
    for (int i = 0; i < 3; i++) begin
      step;
      chk("hold_data", out_data, 8'h11);
    end
    out_ready = 1;
    step;
    out_ready = 0;
    chk("pop1_empty", empty, 1);
    for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i));
    chk("fill_full", full, 1);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_count", count, 4);
    push(8'hFF);
    chk("ovf_set", ovf_sticky, 1);
    chk("ovf_count", count, 4);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_data", out_data, 8'hA0 + i);
      step;
    end
    out_ready = 0;
    chk("drain_empty", empty, 1);
    chk("ovf_keep", ovf_sticky, 1);
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_data = 8'(i);
      step;
      chk("stream_data", out_data, i);
      chk("stream_count", count, 1);
    end
    in_valid = 0;
    step;
    out_ready = 0;
    chk("stream_empty", empty, 1);
    push(8'h20);
    push(8'h21);
    chk("mid_count", count, 2);
    in_valid = 1;
    out_ready = 1;
    for (int i = 0; i < 5; i++) begin
      chk("both_head", out_data, 8'h20 + i);
      in_data = 8'h22 + 8'(i);
      step;
      chk("both_count", count, 2);
    end
    in_valid = 0;
    chk("both_tail0", out_data, 8'h25);
    step;
    chk("both_tail1", out_data, 8'h26);
    step;
    out_ready = 0;
    chk("both_empty", empty, 1);
    clear_scenario(0);
    clear_scenario(1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
